alu_operand_stage: RTL and testbench

- Issue stage directly upstream of the integer ALU.
- Accepts one decoded ALU instruction per cycle, reads operands from an internal 32x32 register file, and resolves RAW/WAW hazards with a per-register pending scoreboard.
- Presents registered op/alt/a/b/rd to the ALU over a valid/ready handshake.
- Takes ALU results back through a writeback port that updates the register file and clears pending bits.

---
 rtl/alu_operand_stage_pkg.sv | 19 +
 rtl/regfile_2r1w.sv | 33 +++
 rtl/alu_operand_stage.sv | 113 +++++++++++
 tb/tb_alu_operand_stage.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_operand_stage_pkg.sv
// Shared definitions for the ALU operand stage: widths and ALU op codes.
package alu_operand_stage_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned NREG      = 32;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SLL  = 3'd1,
    ALU_SLT  = 3'd2,
    ALU_SLTU = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SR   = 3'd5,
    ALU_OR   = 3'd6,
    ALU_AND  = 3'd7
  } alu_op_e;

endpackage

// File: rtl/regfile_2r1w.sv
// Register file with two asynchronous read ports and one synchronous write port.
// Entry 0 is never written and always reads as zero.
module regfile_2r1w
  import alu_operand_stage_pkg::*;
#(
  parameter int unsigned XLEN = alu_operand_stage_pkg::XLEN,
  parameter int unsigned NREG = alu_operand_stage_pkg::NREG
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] ra1,
  input  logic [REG_IDX_W-1:0] ra2,
  output logic [XLEN-1:0]      rd1,
  output logic [XLEN-1:0]      rd2,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] wa,
  input  logic [XLEN-1:0]      wd
);

  logic [XLEN-1:0] mem [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && wa != '0) begin
      mem[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : mem[ra1];
  assign rd2 = (ra2 == '0) ? '0 : mem[ra2];

endmodule

// File: rtl/alu_operand_stage.sv
// Issue stage ahead of the integer ALU: operand read with writeback bypass,
// per-register pending scoreboard for RAW/WAW, single-entry output register.
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int unsigned XLEN = alu_operand_stage_pkg::XLEN,
  parameter int unsigned NREG = alu_operand_stage_pkg::NREG
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_op,
  input  logic                 in_alt,
  input  logic [REG_IDX_W-1:0] in_rs1,
  input  logic [REG_IDX_W-1:0] in_rs2,
  input  logic [REG_IDX_W-1:0] in_rd,
  input  logic [XLEN-1:0]      in_imm,
  input  logic                 in_use_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2:0]           out_op,
  output logic                 out_alt,
  output logic [XLEN-1:0]      out_a,
  output logic [XLEN-1:0]      out_b,
  output logic [REG_IDX_W-1:0] out_rd,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]      wb_data
);

  logic [NREG-1:0] pending;
  logic [NREG-1:0] pend_next;
  logic [NREG-1:0] wb_hit;
  logic [NREG-1:0] pend_eff;
  logic            hazard;
  logic            accept;
  logic [XLEN-1:0] rf_a;
  logic [XLEN-1:0] rf_b;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;

  regfile_2r1w #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (in_rs1),
    .ra2   (in_rs2),
    .rd1   (rf_a),
    .rd2   (rf_b),
    .we    (wb_valid),
    .wa    (wb_rd),
    .wd    (wb_data)
  );

  // A writeback presented this cycle already resolves its register's hazard.
  always_comb begin
    wb_hit = '0;
    if (wb_valid && wb_rd != '0) wb_hit[wb_rd] = 1'b1;
    pend_eff = pending & ~wb_hit;
    hazard   = in_valid & (pend_eff[in_rs1]
                         | (~in_use_imm & pend_eff[in_rs2])
                         | pend_eff[in_rd]);
    in_ready = ~hazard & (~out_valid | out_ready);
    accept   = in_valid & in_ready;
  end

  // Accept-set is applied after writeback-clear so a same-edge reissue keeps rd pending.
  always_comb begin
    pend_next = pending & ~wb_hit;
    if (accept && in_rd != '0) pend_next[in_rd] = 1'b1;
  end

  always_comb begin
    op_a = (wb_valid && wb_rd == in_rs1 && in_rs1 != '0) ? wb_data : rf_a;
    if (in_use_imm) begin
      op_b = in_imm;
    end else begin
      op_b = (wb_valid && wb_rd == in_rs2 && in_rs2 != '0) ? wb_data : rf_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pend_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_op    <= '0;
      out_alt   <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_rd    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_op    <= in_op;
      out_alt   <= in_alt;
      out_a     <= op_a;
      out_b     <= op_b;
      out_rd    <= in_rd;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: reset, bypass, RAW/WAW, backpressure, x0.
module tb_alu_operand_stage;
  import alu_operand_stage_pkg::*;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           in_op;
  logic                 in_alt;
  logic [REG_IDX_W-1:0] in_rs1;
  logic [REG_IDX_W-1:0] in_rs2;
  logic [REG_IDX_W-1:0] in_rd;
  logic [XLEN-1:0]      in_imm;
  logic                 in_use_imm;
  logic                 out_valid;
  logic                 out_ready;
  logic [2:0]           out_op;
  logic                 out_alt;
  logic [XLEN-1:0]      out_a;
  logic [XLEN-1:0]      out_b;
  logic [REG_IDX_W-1:0] out_rd;
  logic                 wb_valid;
  logic [REG_IDX_W-1:0] wb_rd;
  logic [XLEN-1:0]      wb_data;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  alu_operand_stage #(
    .XLEN (32),
    .NREG (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_alt     (in_alt),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_rd      (in_rd),
    .in_imm     (in_imm),
    .in_use_imm (in_use_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_op     (out_op),
    .out_alt    (out_alt),
    .out_a      (out_a),
    .out_b      (out_b),
    .out_rd     (out_rd),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic alt, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [31:0] imm, input logic use_imm);
    in_valid   = 1'b1;
    in_op      = op;
    in_alt     = alt;
    in_rs1     = rs1;
    in_rs2     = rs2;
    in_rd      = rd;
    in_imm     = imm;
    in_use_imm = use_imm;
    #1;
  endtask

  task automatic writeback(input logic en, input logic [4:0] rd, input logic [31:0] data);
    wb_valid = en;
    wb_rd    = rd;
    wb_data  = data;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_alt = 1'b0; in_rs1 = '0;
    in_rs2 = '0; in_rd = '0; in_imm = '0; in_use_imm = 1'b0; out_ready = 1'b1;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;

    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_a", out_a, 32'd0);
    check("rst_out_b", out_b, 32'd0);
    check("rst_out_rd", 32'(out_rd), 32'd0);
    check("rst_out_op", 32'(out_op), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // ADD x5 = x0 + x0
    issue(ALU_ADD, 1'b0, 5'd0, 5'd0, 5'd5, 32'd0, 1'b0);
    check("t1_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("t1_out_valid", 32'(out_valid), 32'd1);
    check("t1_out_a", out_a, 32'd0);
    check("t1_out_b", out_b, 32'd0);
    check("t1_out_rd", 32'(out_rd), 32'd5);
    issue(ALU_ADD, 1'b0, 5'd0, 5'd0, 5'd5, 32'd0, 1'b1);
    check("t1_pending5_waw", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    tick();
    check("t1_drained", 32'(out_valid), 32'd0);

    // Writeback to non-pending x3, then read it with an immediate b
    writeback(1'b1, 5'd3, 32'h0000_1234);
    tick();
    writeback(1'b0, 5'd0, 32'd0);
    issue(ALU_ADD, 1'b0, 5'd3, 5'd0, 5'd8, 32'd7, 1'b1);
    check("t2_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("t2_out_a", out_a, 32'h0000_1234);
    check("t2_out_b", out_b, 32'd7);
    check("t2_out_rd", 32'(out_rd), 32'd8);
    tick();

    // RAW on x4, resolved by same-cycle writeback bypass
    issue(ALU_ADD, 1'b0, 5'd0, 5'd0, 5'd4, 32'd1, 1'b1);
    tick();
    issue(ALU_XOR, 1'b0, 5'd4, 5'd0, 5'd9, 32'd0, 1'b0);
    check("t3_raw_stall0", 32'(in_ready), 32'd0);
    tick();
    check("t3_raw_stall1", 32'(in_ready), 32'd0);
    check("t3_drained", 32'(out_valid), 32'd0);
    writeback(1'b1, 5'd4, 32'h0000_00AA);
    check("t3_wb_release", 32'(in_ready), 32'd1);
    tick();
    writeback(1'b0, 5'd0, 32'd0);
    in_valid = 1'b0;
    check("t3_out_valid", 32'(out_valid), 32'd1);
    check("t3_bypass_a", out_a, 32'h0000_00AA);
    check("t3_out_rd", 32'(out_rd), 32'd9);
    check("t3_out_op", 32'(out_op), 32'(ALU_XOR));
    tick();

    // WAW on x6 with same-edge writeback: the new issue keeps x6 pending
    issue(ALU_ADD, 1'b0, 5'd0, 5'd0, 5'd6, 32'd0, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    writeback(1'b1, 5'd6, 32'h0000_0066);
    issue(ALU_OR, 1'b0, 5'd0, 5'd0, 5'd6, 32'd2, 1'b1);
    check("t4_waw_accept", 32'(in_ready), 32'd1);
    tick();
    writeback(1'b0, 5'd0, 32'd0);
    check("t4_out_rd", 32'(out_rd), 32'd6);
    check("t4_out_b", out_b, 32'd2);
    issue(ALU_ADD, 1'b0, 5'd6, 5'd0, 5'd10, 32'd0, 1'b1);
    check("t4_still_pending", 32'(in_ready), 32'd0);
    writeback(1'b1, 5'd6, 32'h0000_0077);
    check("t4_release", 32'(in_ready), 32'd1);
    tick();
    writeback(1'b0, 5'd0, 32'd0);
    in_valid = 1'b0;
    check("t4_bypass_a", out_a, 32'h0000_0077);
    check("t4_out_rd10", 32'(out_rd), 32'd10);
    tick();

    // Backpressure: x4 (0xAA from regfile) and x3 (0x1234) as a, b
    issue(ALU_SLL, 1'b1, 5'd4, 5'd3, 5'd11, 32'd0, 1'b0);
    tick();
    check("t5_out_a", out_a, 32'h0000_00AA);
    check("t5_out_b", out_b, 32'h0000_1234);
    check("t5_out_alt", 32'(out_alt), 32'd1);
    out_ready = 1'b0;
    issue(ALU_AND, 1'b0, 5'd3, 5'd0, 5'd12, 32'd5, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("t5_bp_in_ready", 32'(in_ready), 32'd0);
      tick();
      check("t5_bp_valid", 32'(out_valid), 32'd1);
      check("t5_bp_a", out_a, 32'h0000_00AA);
      check("t5_bp_rd", 32'(out_rd), 32'd11);
      check("t5_bp_op", 32'(out_op), 32'(ALU_SLL));
    end
    out_ready = 1'b1;
    #1;
    check("t5_release", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("t5_b2b_valid", 32'(out_valid), 32'd1);
    check("t5_b2b_a", out_a, 32'h0000_1234);
    check("t5_b2b_b", out_b, 32'd5);
    check("t5_b2b_rd", 32'(out_rd), 32'd12);
    tick();

    // x0: writeback ignored, reads zero, rd=0 never pending
    writeback(1'b1, 5'd0, 32'hFFFF_FFFF);
    tick();
    writeback(1'b0, 5'd0, 32'd0);
    issue(ALU_ADD, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
    check("t6_in_ready0", 32'(in_ready), 32'd1);
    tick();
    check("t6_x0_a", out_a, 32'd0);
    check("t6_x0_b", out_b, 32'd0);
    check("t6_in_ready1", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("t6_out_valid", 32'(out_valid), 32'd1);
    check("t6_out_rd", 32'(out_rd), 32'd0);
    tick();

    // Mid-operation reset clears output, scoreboard and register file
    issue(ALU_ADD, 1'b0, 5'd3, 5'd0, 5'd13, 32'd0, 1'b1);
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t7_rst_valid", 32'(out_valid), 32'd0);
    check("t7_rst_a", out_a, 32'd0);
    rst_n = 1'b1;
    issue(ALU_ADD, 1'b0, 5'd13, 5'd0, 5'd14, 32'd0, 1'b1);
    check("t7_pending_clear", 32'(in_ready), 32'd1);
    tick();
    issue(ALU_ADD, 1'b0, 5'd3, 5'd0, 5'd15, 32'd0, 1'b1);
    tick();
    in_valid = 1'b0;
    check("t7_rf_cleared", out_a, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
